// File: rtl/wb_victim_buffer_if.sv
// Bus bundle for the victim buffer: LSU lookup, dcache insert/extract, flush and
// memory write-back channels.
interface wb_victim_buffer_if #(
   parameter int TAG_W  = 26,
   parameter int LINE_W = 128
) ();
   logic              lookup_req_i;
   logic [TAG_W-1:0]  lookup_addr_i;
   logic              kill_i;
   logic              victim_hit_o;
   logic [LINE_W-1:0] victim_line_o;
   logic              victim_dirty_o;
   logic              write_to_victim_i;
   logic [TAG_W-1:0]  evict_addr_i;
   logic [LINE_W-1:0] evict_line_i;
   logic              evict_dirty_i;
   logic              write_from_victim_i;
   logic              flush_i;
   logic              busy_o;
   logic              flush_done_o;
   logic              wb_req_o;
   logic [TAG_W-1:0]  wb_addr_o;
   logic [LINE_W-1:0] wb_line_o;
   logic              wb_ack_i;

   modport slave (
      input  lookup_req_i, lookup_addr_i, kill_i,
      input  write_to_victim_i, evict_addr_i, evict_line_i, evict_dirty_i,
      input  write_from_victim_i, flush_i, wb_ack_i,
      output victim_hit_o, victim_line_o, victim_dirty_o,
      output busy_o, flush_done_o, wb_req_o, wb_addr_o, wb_line_o
   );

   modport master (
      output lookup_req_i, lookup_addr_i, kill_i,
      output write_to_victim_i, evict_addr_i, evict_line_i, evict_dirty_i,
      output write_from_victim_i, flush_i, wb_ack_i,
      input  victim_hit_o, victim_line_o, victim_dirty_o,
      input  busy_o, flush_done_o, wb_req_o, wb_addr_o, wb_line_o
   );
endinterface

// File: rtl/wb_victim_buffer.sv
// Fully associative dcache victim buffer with dirty write-back on replacement
// and a sequential flush engine.
module wb_victim_buffer #(
   parameter int NUM_ENTRIES = 4,
   parameter int TAG_W       = 26,
   parameter int LINE_W      = 128
) (
   input logic             clk,
   input logic             rst_n,
   wb_victim_buffer_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ENTRIES - 1);

   typedef enum logic [2:0] {IDLE, WB, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE} state_t;
   state_t state_q, state_d;

   logic [NUM_ENTRIES-1:0] valid_q, dirty_q;
   logic [TAG_W-1:0]       tag_q  [NUM_ENTRIES];
   logic [LINE_W-1:0]      line_q [NUM_ENTRIES];
   logic [IDX_W-1:0]       rp_q, tgt_q, fidx_q;
   logic                   lookup_vld_q;
   logic [TAG_W-1:0]       lookup_addr_q;
   logic [TAG_W-1:0]       hold_tag_q;
   logic [LINE_W-1:0]      hold_line_q;
   logic                   hold_dirty_q;

   logic             hit_any, hit, swap;
   logic [IDX_W-1:0] hit_idx;
   logic             free_any;
   logic [IDX_W-1:0] free_idx;

   always_comb begin
      hit_any  = 1'b0;
      hit_idx  = '0;
      free_any = 1'b0;
      free_idx = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         if (!hit_any && valid_q[i] && tag_q[i] == lookup_addr_q) begin
            hit_any = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!free_any && !valid_q[i]) begin
            free_any = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   assign hit  = rst_n && lookup_vld_q && hit_any;
   assign swap = bus.write_from_victim_i && hit;

   logic             ins_en, ins_hold, hold_ld, tgt_ld, rp_inc, rp_clr;
   logic             f_start, f_inval, f_step;
   logic [IDX_W-1:0] ins_idx;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      ins_en   = 1'b0;
      ins_idx  = '0;
      ins_hold = 1'b0;
      hold_ld  = 1'b0;
      tgt_ld   = 1'b0;
      rp_inc   = 1'b0;
      rp_clr   = 1'b0;
      f_start  = 1'b0;
      f_inval  = 1'b0;
      f_step   = 1'b0;
      unique case (state_q)
         IDLE: begin
            // insert outranks flush; a swap reuses the slot being extracted
            if (bus.write_to_victim_i) begin
               if (swap) begin
                  ins_en  = 1'b1;
                  ins_idx = hit_idx;
               end else if (free_any) begin
                  ins_en  = 1'b1;
                  ins_idx = free_idx;
               end else begin
                  rp_inc = 1'b1;
                  if (valid_q[rp_q] && dirty_q[rp_q]) begin
                     hold_ld = 1'b1;
                     tgt_ld  = 1'b1;
                     state_d = WB;
                  end else begin
                     ins_en  = 1'b1;
                     ins_idx = rp_q;
                  end
               end
            end else if (bus.flush_i) begin
               f_start = 1'b1;
               state_d = FLUSH_SCAN;
            end
         end
         WB: begin
            if (bus.wb_ack_i) begin
               ins_en   = 1'b1;
               ins_idx  = tgt_q;
               ins_hold = 1'b1;
               state_d  = IDLE;
            end
         end
         FLUSH_SCAN: begin
            if (valid_q[fidx_q] && dirty_q[fidx_q]) begin
               state_d = FLUSH_WB;
            end else begin
               f_inval = 1'b1;
               f_step  = 1'b1;
               if (fidx_q == LAST) state_d = FLUSH_DONE;
            end
         end
         FLUSH_WB: begin
            if (bus.wb_ack_i) begin
               f_inval = 1'b1;
               f_step  = 1'b1;
               state_d = (fidx_q == LAST) ? FLUSH_DONE : FLUSH_SCAN;
            end
         end
         FLUSH_DONE: begin
            rp_clr  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q      <= '0;
         dirty_q      <= '0;
         rp_q         <= '0;
         tgt_q        <= '0;
         fidx_q       <= '0;
         lookup_vld_q <= 1'b0;
         hold_tag_q   <= '0;
         hold_line_q  <= '0;
         hold_dirty_q <= 1'b0;
      end else begin
         if (bus.lookup_req_i) begin
            lookup_vld_q  <= 1'b1;
            lookup_addr_q <= bus.lookup_addr_i;
         end else if (bus.kill_i || bus.write_from_victim_i) begin
            lookup_vld_q <= 1'b0;
         end
         // invalidations first so a same-cycle install into that slot wins
         if (swap) begin
            valid_q[hit_idx] <= 1'b0;
            dirty_q[hit_idx] <= 1'b0;
         end
         if (f_inval) begin
            valid_q[fidx_q] <= 1'b0;
            dirty_q[fidx_q] <= 1'b0;
         end
         if (ins_en) begin
            valid_q[ins_idx] <= 1'b1;
            dirty_q[ins_idx] <= ins_hold ? hold_dirty_q : bus.evict_dirty_i;
            tag_q[ins_idx]   <= ins_hold ? hold_tag_q   : bus.evict_addr_i;
            line_q[ins_idx]  <= ins_hold ? hold_line_q  : bus.evict_line_i;
         end
         if (hold_ld) begin
            hold_tag_q   <= bus.evict_addr_i;
            hold_line_q  <= bus.evict_line_i;
            hold_dirty_q <= bus.evict_dirty_i;
         end
         if (tgt_ld) tgt_q <= rp_q;
         if (rp_clr)      rp_q <= '0;
         else if (rp_inc) rp_q <= rp_q + 1'b1;
         if (f_start)     fidx_q <= '0;
         else if (f_step) fidx_q <= fidx_q + 1'b1;
      end
   end

   logic             wb_req;
   logic [IDX_W-1:0] wb_idx;

   assign wb_req = rst_n && (state_q == WB || state_q == FLUSH_WB);
   assign wb_idx = (state_q == WB) ? tgt_q : fidx_q;

   assign bus.victim_hit_o   = hit;
   assign bus.victim_line_o  = hit ? line_q[hit_idx] : '0;
   assign bus.victim_dirty_o = hit && dirty_q[hit_idx];
   assign bus.busy_o         = rst_n && (state_q != IDLE);
   assign bus.flush_done_o   = rst_n && (state_q == FLUSH_DONE);
   assign bus.wb_req_o       = wb_req;
   assign bus.wb_addr_o      = wb_req ? tag_q[wb_idx]  : '0;
   assign bus.wb_line_o      = wb_req ? line_q[wb_idx] : '0;
endmodule

// File: tb/tb_wb_victim_buffer.sv
// Directed bench for wb_victim_buffer: a per-cycle behavioural model plus
// hand-computed expectations for each scenario.
module tb_wb_victim_buffer;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wb_victim_buffer_if #(.TAG_W(26), .LINE_W(128)) bus ();

   wb_victim_buffer #(.NUM_ENTRIES(N), .TAG_W(26), .LINE_W(128)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   function automatic logic [127:0] ldat(input logic [25:0] a);
      return {4{32'hCAFE_0000 | {6'b0, a}}};
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %b want %b", nm, $time, act, exp);
      end
   endtask

   task automatic chka(input string nm, input logic [25:0] act, input logic [25:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
      end
   endtask

   task automatic chkl(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_WB, M_SCAN, M_FWB, M_DONE} mode_t;
   mode_t        m_mode = M_IDLE;
   bit           m_v [N];
   bit           m_d [N];
   logic [25:0]  m_tag [N];
   logic [127:0] m_line [N];
   int           m_rp = 0, m_fi = 0, m_tgt = 0;
   bit           m_lv = 0;
   logic [25:0]  m_la = '0, m_pa = '0, m_ha = '0;
   logic [127:0] m_pl = '0, m_hl = '0;
   bit           m_hd = 0;

   function automatic int m_find(input logic [25:0] a);
      for (int i = 0; i < N; i++)
         if (m_v[i] && m_tag[i] == a) return i;
      return -1;
   endfunction

   function automatic int m_free();
      for (int i = 0; i < N; i++)
         if (!m_v[i]) return i;
      return -1;
   endfunction

   always @(posedge clk) begin
      int hi, fi, ii;
      bit hit, swap, ins, idp;
      logic [25:0]  ia;
      logic [127:0] il;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_v[i] = 0;
            m_d[i] = 0;
         end
         m_rp = 0; m_lv = 0; m_mode = M_IDLE;
      end else begin
         hi   = m_find(m_la);
         hit  = m_lv && hi >= 0;
         swap = bus.write_from_victim_i && hit;
         ins = 0; ii = 0; ia = bus.evict_addr_i; il = bus.evict_line_i; idp = bus.evict_dirty_i;
         case (m_mode)
            M_IDLE: begin
               if (bus.write_to_victim_i) begin
                  fi = m_free();
                  if (swap) begin
                     ins = 1; ii = hi;
                  end else if (fi >= 0) begin
                     ins = 1; ii = fi;
                  end else begin
                     ii   = m_rp;
                     m_rp = (m_rp + 1) % N;
                     if (m_d[ii]) begin
                        m_mode = M_WB; m_tgt = ii;
                        m_pa = m_tag[ii]; m_pl = m_line[ii];
                        m_ha = ia; m_hl = il; m_hd = idp;
                     end else ins = 1;
                  end
               end else if (bus.flush_i) begin
                  m_mode = M_SCAN; m_fi = 0;
               end
            end
            M_WB: if (bus.wb_ack_i) begin
               ins = 1; ii = m_tgt; ia = m_ha; il = m_hl; idp = m_hd;
               m_mode = M_IDLE;
            end
            M_SCAN: begin
               if (m_v[m_fi] && m_d[m_fi]) begin
                  m_mode = M_FWB; m_pa = m_tag[m_fi]; m_pl = m_line[m_fi];
               end else begin
                  m_v[m_fi] = 0; m_d[m_fi] = 0;
                  if (m_fi == N - 1) m_mode = M_DONE;
                  else m_fi++;
               end
            end
            M_FWB: if (bus.wb_ack_i) begin
               m_v[m_fi] = 0; m_d[m_fi] = 0;
               if (m_fi == N - 1) m_mode = M_DONE;
               else begin
                  m_fi++; m_mode = M_SCAN;
               end
            end
            M_DONE: begin
               m_rp = 0; m_mode = M_IDLE;
            end
            default: m_mode = M_IDLE;
         endcase
         if (swap) begin
            m_v[hi] = 0; m_d[hi] = 0;
         end
         if (ins) begin
            m_v[ii] = 1; m_d[ii] = idp; m_tag[ii] = ia; m_line[ii] = il;
         end
         if (bus.lookup_req_i) begin
            m_lv = 1; m_la = bus.lookup_addr_i;
         end else if (bus.kill_i || bus.write_from_victim_i) m_lv = 0;
      end
   end

   always @(negedge clk) begin
      int hi;
      bit e_hit, e_wb;
      hi    = m_find(m_la);
      e_hit = rst_n && m_lv && hi >= 0;
      e_wb  = rst_n && (m_mode == M_WB || m_mode == M_FWB);
      chk1("m_hit", bus.victim_hit_o, e_hit);
      chkl("m_line", bus.victim_line_o, e_hit ? m_line[hi] : 128'h0);
      chk1("m_dirty", bus.victim_dirty_o, e_hit && m_d[hi]);
      chk1("m_busy", bus.busy_o, rst_n && m_mode != M_IDLE);
      chk1("m_fdone", bus.flush_done_o, rst_n && m_mode == M_DONE);
      chk1("m_wbreq", bus.wb_req_o, e_wb);
      chka("m_wbaddr", bus.wb_addr_o, e_wb ? m_pa : 26'h0);
      chkl("m_wbline", bus.wb_line_o, e_wb ? m_pl : 128'h0);
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic insert(input logic [25:0] a, input logic d);
      bus.write_to_victim_i = 1'b1;
      bus.evict_addr_i      = a;
      bus.evict_line_i      = ldat(a);
      bus.evict_dirty_i     = d;
      cyc();
      bus.write_to_victim_i = 1'b0;
   endtask

   task automatic lookup(input logic [25:0] a);
      bus.lookup_req_i  = 1'b1;
      bus.lookup_addr_i = a;
      cyc();
      bus.lookup_req_i  = 1'b0;
   endtask

   task automatic fill4(input logic d0, input logic d1, input logic d2, input logic d3);
      insert(26'h10, d0);
      insert(26'h20, d1);
      insert(26'h30, d2);
      insert(26'h40, d3);
   endtask

   initial begin
      int bn, hs, dn;
      logic [25:0] seen [$];
      rst_n = 1'b0;
      bus.lookup_req_i = 0; bus.lookup_addr_i = '0; bus.kill_i = 0;
      bus.write_to_victim_i = 0; bus.evict_addr_i = '0; bus.evict_line_i = '0;
      bus.evict_dirty_i = 0; bus.write_from_victim_i = 0; bus.flush_i = 0; bus.wb_ack_i = 0;
      #1;
      chk1("rst_hit", bus.victim_hit_o, 1'b0);
      chk1("rst_busy", bus.busy_o, 1'b0);
      chk1("rst_wbreq", bus.wb_req_o, 1'b0);
      do_reset();

      // insert clean 0x10 and dirty 0x20, then look up 0x20
      insert(26'h10, 0);
      insert(26'h20, 1);
      lookup(26'h20);
      chk1("s1_hit", bus.victim_hit_o, 1'b1);
      chk1("s1_dirty", bus.victim_dirty_o, 1'b1);
      chkl("s1_line", bus.victim_line_o, 128'hCAFE0020_CAFE0020_CAFE0020_CAFE0020);
      bus.kill_i = 1'b1;
      cyc();
      bus.kill_i = 1'b0;
      chk1("s1_kill", bus.victim_hit_o, 1'b0);
      lookup(26'h30);
      chk1("s1_miss", bus.victim_hit_o, 1'b0);
      chkl("s1_miss_line", bus.victim_line_o, 128'h0);
      bus.write_from_victim_i = 1'b1;   // no hit: must be ignored
      cyc();
      bus.write_from_victim_i = 1'b0;
      lookup(26'h10);
      chk1("s1_nohit_wfv", bus.victim_hit_o, 1'b1);

      // full and clean: replacement at rp=0, then rp=1
      do_reset();
      fill4(0, 0, 0, 0);
      insert(26'h50, 0);
      chk1("s2_wbreq", bus.wb_req_o, 1'b0);
      chk1("s2_busy", bus.busy_o, 1'b0);
      lookup(26'h10);
      chk1("s2_old_gone", bus.victim_hit_o, 1'b0);
      lookup(26'h20);
      chk1("s2_e1_kept", bus.victim_hit_o, 1'b1);
      insert(26'h60, 0);
      lookup(26'h20);
      chk1("s2_rp1_repl", bus.victim_hit_o, 1'b0);
      lookup(26'h30);
      chk1("s2_e2_kept", bus.victim_hit_o, 1'b1);

      // full with entry 0 dirty: write-back with ack delayed 3 cycles
      do_reset();
      fill4(1, 0, 0, 0);
      insert(26'h60, 0);
      bn = 0;
      if (bus.busy_o) bn++;
      chk1("s3_wbreq", bus.wb_req_o, 1'b1);
      chka("s3_wbaddr", bus.wb_addr_o, 26'h10);
      chkl("s3_wbline", bus.wb_line_o, 128'hCAFE0010_CAFE0010_CAFE0010_CAFE0010);
      bus.lookup_req_i = 1; bus.lookup_addr_i = 26'h60;
      bus.write_to_victim_i = 1; bus.evict_addr_i = 26'h77;
      bus.evict_line_i = ldat(26'h77); bus.evict_dirty_i = 0;
      cyc();
      bus.lookup_req_i = 0; bus.write_to_victim_i = 0;
      if (bus.busy_o) bn++;
      chk1("s3_not_yet", bus.victim_hit_o, 1'b0);
      lookup(26'h10);
      if (bus.busy_o) bn++;
      chk1("s3_wb_entry_hits", bus.victim_hit_o, 1'b1);
      chka("s3_wbaddr_stable", bus.wb_addr_o, 26'h10);
      cyc();
      if (bus.busy_o) bn++;
      bus.wb_ack_i = 1'b1;
      cyc();
      bus.wb_ack_i = 1'b0;
      chk1("s3_busy_off", bus.busy_o, 1'b0);
      chk1("s3_wbreq_off", bus.wb_req_o, 1'b0);
      chk1("s3_busy_cycles", bn == 4, 1'b1);
      lookup(26'h60);
      chk1("s3_installed", bus.victim_hit_o, 1'b1);
      chkl("s3_inst_line", bus.victim_line_o, 128'hCAFE0060_CAFE0060_CAFE0060_CAFE0060);
      lookup(26'h77);
      chk1("s3_busy_insert_ignored", bus.victim_hit_o, 1'b0);

      // swap: extract 0x30 and insert 0x70 in the same cycle
      do_reset();
      fill4(0, 0, 0, 0);
      lookup(26'h30);
      chk1("s4_hit", bus.victim_hit_o, 1'b1);
      bus.write_from_victim_i = 1;
      bus.write_to_victim_i = 1; bus.evict_addr_i = 26'h70;
      bus.evict_line_i = ldat(26'h70); bus.evict_dirty_i = 0;
      cyc();
      bus.write_from_victim_i = 0; bus.write_to_victim_i = 0;
      chk1("s4_lookup_cleared", bus.victim_hit_o, 1'b0);
      lookup(26'h30);
      chk1("s4_old_miss", bus.victim_hit_o, 1'b0);
      lookup(26'h70);
      chk1("s4_new_hit", bus.victim_hit_o, 1'b1);
      lookup(26'h10);
      chk1("s4_rp_untouched", bus.victim_hit_o, 1'b1);

      // flush with entries 1 and 3 dirty; flush alongside insert is dropped
      do_reset();
      insert(26'h10, 0);
      insert(26'h20, 1);
      insert(26'h30, 0);
      bus.flush_i = 1'b1;
      insert(26'h40, 1);
      bus.flush_i = 1'b0;
      chk1("s5_flush_dropped", bus.busy_o, 1'b0);
      bus.flush_i = 1'b1;
      cyc();
      bus.flush_i = 1'b0;
      chk1("s5_busy", bus.busy_o, 1'b1);
      hs = 0; dn = 0;
      for (int k = 0; k < 30; k++) begin
         if (bus.flush_done_o) dn++;
         if (bus.wb_req_o) begin
            seen.push_back(bus.wb_addr_o);
            hs++;
         end
         bus.wb_ack_i = bus.wb_req_o;
         cyc();
      end
      bus.wb_ack_i = 1'b0;
      chk1("s5_two_wb", hs == 2, 1'b1);
      if (seen.size() == 2) begin
         chka("s5_wb0", seen[0], 26'h20);
         chka("s5_wb1", seen[1], 26'h40);
      end
      chk1("s5_done_once", dn == 1, 1'b1);
      chk1("s5_idle", bus.busy_o, 1'b0);
      for (int a = 1; a <= 4; a++) begin
         lookup(26'(a * 16));
         chk1("s5_all_invalid", bus.victim_hit_o, 1'b0);
      end

      // reset during a write-back
      do_reset();
      fill4(1, 0, 0, 0);
      insert(26'h60, 0);
      chk1("s6_wbreq", bus.wb_req_o, 1'b1);
      rst_n = 1'b0;
      cyc();
      chk1("s6_wbreq_rst", bus.wb_req_o, 1'b0);
      chk1("s6_busy_rst", bus.busy_o, 1'b0);
      rst_n = 1'b1;
      lookup(26'h10);
      chk1("s6_miss10", bus.victim_hit_o, 1'b0);
      lookup(26'h20);
      chk1("s6_miss20", bus.victim_hit_o, 1'b0);
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
